// File: rtl/rr_packet_mux.sv
// N-to-1 packet stream multiplexer with packet-level locking and round-robin or fixed-priority arbitration.
// Optional source tagging (src_out, pkt_start) is enabled by defining RR_PKT_MUX_SRC_ID_EN.
module rr_packet_mux #(
    parameter int P_DATA_WIDTH  = 32,
    parameter int P_NUM_INPUTS  = 4,
    parameter int P_ROUND_ROBIN = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in [P_NUM_INPUTS],
    input  logic                          last_in  [P_NUM_INPUTS],
    input  logic [P_DATA_WIDTH-1:0]       data_in  [P_NUM_INPUTS],
    output logic                          ready_in [P_NUM_INPUTS],
    output logic                          valid_out,
    output logic                          last_out,
    output logic [P_DATA_WIDTH-1:0]       data_out,
    input  logic                          ready_out
`ifdef RR_PKT_MUX_SRC_ID_EN
    ,
    output logic [$clog2(P_NUM_INPUTS)-1:0] src_out,
    output logic                          pkt_start
`endif
);

    // Handshake: a beat moves when valid and ready are both high on a rising edge;
    // sources hold valid/data/last stable until accepted, ready never depends on valid.

    localparam int N     = P_NUM_INPUTS;
    localparam int SEL_W = $clog2(P_NUM_INPUTS);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [SEL_W-1:0] sel, sel_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [SEL_W-1:0] sel_inc;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] winner;
    logic             active;
    logic             any_req;
    logic             fire;
    logic             finish;
    logic             arb;

    assign active = (state == ST_LOCKED);

    always_comb begin
        valid_out = active && valid_in[sel];
        last_out  = last_in[sel];
        data_out  = data_in[sel];
    end

    // ready_in is a function of registered state and ready_out only.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ready_in[i] = active && (sel == SEL_W'(i)) && ready_out;
        end
    end

    assign fire    = valid_out && ready_out;
    assign finish  = fire && last_out;
    assign arb     = !active || finish;
    assign sel_inc = (sel == SEL_W'(N - 1)) ? '0 : sel + SEL_W'(1);

    // When a packet finishes, search starts just past the finishing input so it can
    // still be re-granted last if it is the only requester.
    always_comb begin
        base = '0;
        if (P_ROUND_ROBIN != 0) begin
            base = finish ? sel_inc : ptr;
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        winner  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(base) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (valid_in[idx]) begin
                any_req = 1'b1;
                winner  = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        if (finish && (P_ROUND_ROBIN != 0)) begin
            ptr_n = sel_inc;
        end
        if (arb) begin
            if (any_req) begin
                state_n = ST_LOCKED;
                sel_n   = winner;
            end else begin
                state_n = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
        end
    end

`ifdef RR_PKT_MUX_SRC_ID_EN
    logic first, first_n;

    // Set on every grant, cleared once a non-final beat of the packet is accepted.
    always_comb begin
        first_n = first;
        if (arb && any_req) begin
            first_n = 1'b1;
        end else if (fire && !last_out) begin
            first_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first <= 1'b0;
        end else begin
            first <= first_n;
        end
    end

    assign src_out   = sel;
    assign pkt_start = first && valid_out;
`endif

endmodule

// File: tb/tb_rr_packet_mux.sv
// Randomized bench for rr_packet_mux: three instances (RR N=4, fixed N=4, RR N=3) driven in
// lockstep and compared each cycle against a transaction-level reference model.
module tb_rr_packet_mux;

    localparam int W   = 32;
    localparam int NI  = 3;
    localparam int CYC = 3000;

    function automatic int cfg_n(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic int cfg_rr(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         ro  [NI];
    logic         tv  [NI][4];
    logic         tl  [NI][4];
    logic [W-1:0] td  [NI][4];
    logic         tr  [NI][4];
    logic         tvo [NI];
    logic         tlo [NI];
    logic [W-1:0] tdo [NI];
`ifdef RR_PKT_MUX_SRC_ID_EN
    logic [4:0]   tsrc [NI];
    logic         tps  [NI];
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] exp_q [$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N  = (g == 2) ? 3 : 4;
        localparam int RR = (g == 1) ? 0 : 1;
        localparam int SW = $clog2(N);

        logic         v [N];
        logic         l [N];
        logic         r [N];
        logic [W-1:0] d [N];

        for (genvar i = 0; i < 4; i++) begin : g_pin
            if (i < N) begin : g_on
                assign v[i]     = tv[g][i];
                assign l[i]     = tl[g][i];
                assign d[i]     = td[g][i];
                assign tr[g][i] = r[i];
            end else begin : g_off
                assign tr[g][i] = 1'b0;
            end
        end

`ifdef RR_PKT_MUX_SRC_ID_EN
        logic [SW-1:0] src;
        assign tsrc[g] = 5'(src);
`endif

        rr_packet_mux #(
            .P_DATA_WIDTH (W),
            .P_NUM_INPUTS (N),
            .P_ROUND_ROBIN(RR)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .valid_in (v),
            .last_in  (l),
            .data_in  (d),
            .ready_in (r),
            .valid_out(tvo[g]),
            .last_out (tlo[g]),
            .data_out (tdo[g]),
            .ready_out(ro[g])
`ifdef RR_PKT_MUX_SRC_ID_EN
            ,
            .src_out  (src),
            .pkt_start(tps[g])
`endif
        );
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- stimulus, model, scoreboard ----------------
    initial begin : main
        int   rem  [NI][4];
        int   bidx [NI][4];
        logic hs   [NI][4];
        int   m_active [NI];
        int   m_sel    [NI];
        int   m_ptr    [NI];
        int   pv_tab [6];
        int   pr_tab [6];
        int   n, s, seg, base, win, idx, pv;
        logic e_valid, fire, fin, arb, prev_rst;
        logic [W:0] got_beat, exp_beat;

        pv_tab = '{100, 80, 40, 100, 60, 90};
        pr_tab = '{100, 60, 100, 30, 90, 100};
        rst      = 1'b1;
        prev_rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            ro[k]       = 1'b0;
            m_active[k] = 0;
            m_sel[k]    = 0;
            m_ptr[k]    = 0;
            for (int i = 0; i < 4; i++) begin
                tv[k][i]   = 1'b0;
                tl[k][i]   = 1'b0;
                td[k][i]   = '0;
                rem[k][i]  = 0;
                bidx[k][i] = 0;
                hs[k][i]   = 1'b0;
            end
        end

        for (int cyc = 0; cyc < CYC; cyc++) begin
            @(posedge clk);
            #1;
            seg = cyc / 500;
            pv  = pv_tab[seg];
            rst = (cyc < 2) || (cyc == 1000) || (cyc == 2200);
            for (int k = 0; k < NI; k++) begin
                n     = cfg_n(k);
                ro[k] = (int'($urandom_range(0, 99)) < pr_tab[seg]);
                for (int i = 0; i < n; i++) begin
                    if (rst) begin
                        // Upstream sources are reset together with the mux.
                        tv[k][i]   = 1'b0;
                        tl[k][i]   = 1'b0;
                        rem[k][i]  = 0;
                        bidx[k][i] = 0;
                        hs[k][i]   = 1'b0;
                    end else begin
                        if (hs[k][i]) begin
                            bidx[k][i] = tl[k][i] ? 0 : bidx[k][i] + 1;
                            rem[k][i]  = rem[k][i] - 1;
                            tv[k][i]   = 1'b0;
                            hs[k][i]   = 1'b0;
                        end
                        if (!tv[k][i]) begin
                            if (rem[k][i] == 0 && int'($urandom_range(0, 99)) < pv) begin
                                rem[k][i] = int'($urandom_range(1, 4));
                            end
                            if (rem[k][i] > 0 && int'($urandom_range(0, 99)) < pv) begin
                                tv[k][i] = 1'b1;
                                td[k][i] = $urandom;
                                tl[k][i] = (rem[k][i] == 1);
                            end
                        end
                    end
                end
            end

            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                n = cfg_n(k);
                s = m_sel[k];

                if (prev_rst) begin
                    check_eq($sformatf("k%0d_rst_valid_out", k), 64'(tvo[k]), 64'(0));
                    for (int i = 0; i < n; i++) begin
                        check_eq($sformatf("k%0d_rst_ready_in%0d", k, i), 64'(tr[k][i]), 64'(0));
                    end
                end

                e_valid = (m_active[k] != 0) && tv[k][s];
                fire    = e_valid && ro[k];
                fin     = fire && tl[k][s];
                arb     = (m_active[k] == 0) || fin;

                check_eq($sformatf("k%0d_valid_out", k), 64'(tvo[k]), 64'(e_valid));
                for (int i = 0; i < n; i++) begin
                    check_eq($sformatf("k%0d_ready_in%0d", k, i), 64'(tr[k][i]),
                             64'((m_active[k] != 0) && (s == i) && ro[k]));
                    hs[k][i] = (m_active[k] != 0) && (s == i) && ro[k] && tv[k][i] && !rst;
                end

                if (e_valid) begin
`ifdef RR_PKT_MUX_SRC_ID_EN
                    check_eq($sformatf("k%0d_src_out", k), 64'(tsrc[k]), 64'(s));
                    check_eq($sformatf("k%0d_pkt_start", k), 64'(tps[k]), 64'(bidx[k][s] == 0));
`endif
                    if (fire) begin
                        exp_q.push_back({tl[k][s], td[k][s]});
                        got_beat = {tlo[k], tdo[k]};
                        exp_beat = exp_q.pop_front();
                        check_eq($sformatf("k%0d_beat_src%0d", k, s), 64'(got_beat), 64'(exp_beat));
                    end
                end

                // Winner: first requester at/after the search base, wrapping modulo n.
                if (cfg_rr(k) == 0) begin
                    base = 0;
                end else begin
                    base = fin ? (s + 1) % n : m_ptr[k];
                end
                win = -1;
                for (int j = 0; j < n; j++) begin
                    idx = (base + j) % n;
                    if (win < 0 && tv[k][idx]) begin
                        win = idx;
                    end
                end

                if (rst) begin
                    m_active[k] = 0;
                    m_sel[k]    = 0;
                    m_ptr[k]    = 0;
                end else begin
                    if (fin && cfg_rr(k) != 0) begin
                        m_ptr[k] = (s + 1) % n;
                    end
                    if (arb) begin
                        if (win >= 0) begin
                            m_active[k] = 1;
                            m_sel[k]    = win;
                        end else begin
                            m_active[k] = 0;
                        end
                    end
                end
            end
            prev_rst = rst;
        end

        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_packet_mux.md
Name: rr_packet_mux

Overview:
- Parametrised N-to-1 packet stream multiplexer with packet-level locking.
- Arbitration is selectable: round-robin or fixed priority.
- Switches back-to-back between packets with no idle cycle.
- Accepts bursty, non-continuous input streams.
- Sits between multiple packet producers (e.g. per-port framers) and a single shared downstream stream interface.

Parameters:
P_DATA_WIDTH, 32, width of data beats
P_NUM_INPUTS, 4, number of input streams; legal range 2..32, power of two not required
P_ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins
localparam SEL_W = $clog2(P_NUM_INPUTS), width of the internal selector

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
valid_in  input  1 x P_NUM_INPUTS (unpacked)  per-input beat valid
last_in  input  1 x P_NUM_INPUTS (unpacked)  per-input end-of-packet marker, qualified by valid_in
data_in  input  P_DATA_WIDTH x P_NUM_INPUTS (unpacked)  per-input data
ready_in  output  1 x P_NUM_INPUTS (unpacked)  per-input ready
valid_out  output  1  output beat valid
last_out  output  1  output end-of-packet
data_out  output  P_DATA_WIDTH  output data
ready_out  input  1  downstream ready

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- State registers:
  - active (1b): a packet is locked.
  - sel (SEL_W): currently granted input.
  - ptr (SEL_W): round-robin highest-priority index.
- Reset values: active=0, sel=0, ptr=0. Consequently ready_in all 0 and valid_out=0 in the cycle after rst is sampled high.
- Beat transfer: a beat transfers when valid_out && ready_out.
  - Input i is handshaken when valid_in[i] && ready_in[i].
- Combinational outputs:
  - valid_out = active && valid_in[sel]. Bubbles inside a packet are allowed: valid_out follows the granted input.
  - last_out = last_in[sel]; data_out = data_in[sel]. Both are don't-care when valid_out=0.
  - ready_in[i] = active && (sel==i) && ready_out.
  - No combinational path from any valid_in or last_in to any ready_in.
- Arbitration request vector: req = valid_in.
  - Round-robin: the winner is the first asserted req at or after index ptr, wrapping modulo P_NUM_INPUTS.
  - Fixed priority: the winner is the lowest asserted index.
  - Indices >= P_NUM_INPUTS never exist; sel never takes an out-of-range value.
- Arbitration event (arb) occurs when either:
  - (a) !active, or
  - (b) active && valid_out && ready_out && last_out (final beat accepted this cycle).
- On arb:
  - If any req is set: active<=1, sel<=winner.
  - Otherwise: active<=0, sel holds.
  - In case (b), req[sel] is included: a single requester is re-granted immediately.
- ptr update: when a final beat is accepted, ptr<=(sel+1) mod N. In fixed mode ptr is unused and held at 0.
- Latency:
  - Idle to first output beat: 1 cycle after valid_in rises.
  - Final beat accepted to next packet's first beat: 0 idle cycles, provided the next requester is valid in the cycle of the final beat.
- Lock: while active and not finishing, sel is frozen regardless of other valid_in.
- ready_out=0 holds all state; data_out tracks data_in[sel].
- Single-beat packets (valid&&last on the first beat) are legal and may be switched every cycle.
- Reset mid-packet: the packet is abandoned with no flush; the upstream source must also be reset.
- Sources must hold valid_in/data/last stable until handshaken. They must not deassert a packet's request between arbitration and the first beat.

Optional Feature:
RR_PKT_MUX_SRC_ID_EN:
- Defined: adds output port src_out (SEL_W) = sel, valid with valid_out, so downstream can tag packets with the originating input.
  - Also adds output pkt_start (1b), high on a packet's first output beat. It is tracked by a register first set on arb grant and cleared on any accepted non-last beat.
- Undefined: neither port exists, and no first-beat register is instantiated.

Test Plan:
- Round-robin fairness: N=4, P_ROUND_ROBIN=1, all inputs continuously sending 2-beat packets, ready_out=1 -> output packet sources ordered 0,1,2,3,0,1…; no cycle with valid_out=0 after the first.
- Fixed priority: P_ROUND_ROBIN=0, inputs 1 and 3 both continuously valid -> only input 1 is ever granted; input 3 ready_in stays 0.
- Lock and backpressure: input 2 sends a 5-beat packet, ready_out toggles 1,0,1,0…, input 0 asserts valid mid-packet -> all 5 beats from input 2 in order; input 0 is granted on the cycle after beat 5 is accepted.
- Bubble inside packet: granted input drops valid for 3 cycles mid-packet -> valid_out=0 for those 3 cycles, sel unchanged, remaining beats delivered.
- Reset mid-packet: rst high for 1 cycle during beat 2 of 4 -> next cycle active=0, valid_out=0, all ready_in=0; after reset, the first grant goes to the lowest valid index (ptr=0).
- Non-power-of-two, with RR_PKT_MUX_SRC_ID_EN defined: N=3, single-beat packets on all inputs -> src_out sequence 0,1,2,0…, pkt_start=1 on every beat; sel never equals 3.
